addsub_seq: RTL and testbench
=============================

# addsub_seq

Parametrised multi-cycle adder/subtractor for the ALU datapath. It generalises the fixed 2-bit ripple adder to WIDTH bits and adds a subtract mode. Each clock it processes DIGIT bits through a DIGIT-bit ripple slice, carrying between slices in a register. It uses a start/busy/done handshake and reports carry, signed-overflow and zero flags with the registered result.

## Interface
- WIDTH, 8, operand/result width in bits; must be >= 2.
- DIGIT, 2, bits processed per clock; must divide WIDTH; N = WIDTH/DIGIT slices.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only while busy=0.
- mode  in  1  0 = add (a+b+cin), 1 = subtract (a-b-cin); sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- cin  in  1  carry-in (add) / borrow-in (subtract); sampled with start.
- busy  out  1  high while slices are being processed.
- done  out  1  one-cycle pulse: result and flags just updated.
- result  out  WIDTH  registered result; held until next completion.
- cout  out  1  add: carry out of MSB; subtract: 1 = no borrow, 0 = borrow.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  result == 0.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1.
  - RUN -> DONE after N slice cycles.
  - DONE -> IDLE unconditionally, or DONE -> RUN if start=1.
- Accept, meaning start=1 while busy=0 in IDLE or DONE:
  - Latch a and b' = mode ? ~b : b.
  - Carry register = mode ? ~cin : cin.
  - Slice counter = 0.
- RUN, each cycle:
  - Slice k = counter takes bits [k*DIGIT +: DIGIT] of the latched a and b'.
  - Add them with the carry register through a DIGIT-bit ripple chain.
  - Write the DIGIT sum bits into an internal accumulator at the same position.
  - Update the carry register and increment the counter.
  - On the last slice (k = N-1), also capture the carry into bit WIDTH-1 for ovf.
- Completion, on the edge that processes slice N-1:
  - Copy the accumulator to result.
  - Set cout = final carry, ovf = carry-into-MSB XOR final carry, zero = (accumulator == 0).
  - Enter DONE.
- Arithmetic is modulo 2^WIDTH; cout and ovf report the excess; there is no saturation.
- start while busy=1 is ignored, with no queueing and no effect on the current operation.
- a, b, mode and cin may change freely after acceptance; only the latched copies are used.
- result, cout, ovf and zero change only at completion. While busy they keep the previous operation's values.

## Timing
- Reset values, applied immediately on rst_n=0, independent of clk: state IDLE, busy=0, done=0, result=0, cout=0, ovf=0, zero=0.
  - zero resets to 0, not 1; it reflects only completed operations.
  - Internal registers also clear.
- Reset asserted mid-RUN aborts the operation: no done pulse, and outputs go to reset values.
- Let the accept edge be edge 0.
  - busy=1 after edges 0 .. N-1.
  - After edge N: busy=0, done=1, and new result and flags are visible.
  - After edge N+1: done=0, unless another completion occurs.
- Latency is N+1 clocks from the accept edge to done falling. The result is visible from edge N onward.
- Back-to-back: a start sampled at edge N+1 (during the DONE cycle) is accepted. Busy then rises after edge N+1, giving one operation per N+1 cycles.
- With N=1 (DIGIT=WIDTH), busy is high for exactly one cycle.
- done and busy are never both high.

## Test plan
- WIDTH=8, DIGIT=2; add a=8'h7F, b=8'h01, cin=0 -> after 4 busy cycles, done pulses once; result=8'h80, cout=0, ovf=1, zero=0.
- Subtract a=8'h05, b=8'h05, cin=0 -> result=8'h00, cout=1, ovf=0, zero=1. Then subtract a=8'h00, b=8'h01 -> result=8'hFF, cout=0 (borrow), ovf=0.
- Add a=8'hFF, b=8'h01, cin=1 -> result=8'h01, cout=1, ovf=0.
  - Change a, b, mode and pulse start during busy: no effect on this result or on the cycle count.
  - Old result stays stable until done.
- Issue start in the DONE cycle of one operation (8'h10+8'h20) followed by 8'h80-8'h01 -> second busy rises after edge 5. Results are 8'h30, then 8'h7F with ovf=1 and cout=1.
- Drop rst_n low asynchronously mid-RUN at slice 2 -> all outputs 0 immediately, no done pulse. After release, a new add 8'h03+8'h04 completes normally with result 8'h07.
- Parameter sweep (WIDTH=8/DIGIT=1, WIDTH=8/DIGIT=8, WIDTH=16/DIGIT=4) with 1000 random operands, modes and cin each:
  - result, cout, ovf and zero match a reference model.
  - busy lasts exactly WIDTH/DIGIT cycles per operation.

Source files
------------

// File: rtl/addsub_seq_if.sv
// Start/busy/done handshake bundle for the sequential adder/subtractor.
// The requester drives the operands; the datapath drives status and result.
interface addsub_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, mode, a, b, cin,
        input  busy, done, result, cout, ovf, zero
    );

    modport slave (
        input  start, mode, a, b, cin,
        output busy, done, result, cout, ovf, zero
    );
endinterface

// File: rtl/addsub_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor that handles DIGIT bits per clock.
// A carry register links the slices; flags and result update only at completion.
module addsub_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    addsub_seq_if.slave bus
);
    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({DIGIT{1'b1}});

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_c;
    logic             accept_c;

    logic [31:0]      base;
    logic [DIGIT-1:0] slice_a;
    logic [DIGIT-1:0] slice_b;
    logic [DIGIT-1:0] slice_sum;
    logic [DIGIT:0]   chain;

    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    assign last_c   = (cnt == CW'(N - 1));
    assign accept_c = bus.start && (state != S_RUN);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; start is ignored while RUN
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_RUN;
            S_RUN:   if (last_c) state_nxt = S_DONE;
            S_DONE:  state_nxt = bus.start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // One DIGIT-bit ripple slice; chain[DIGIT-1] is the carry into the slice MSB
    always_comb begin
        base      = 32'(cnt) * 32'(DIGIT);
        slice_a   = DIGIT'(op_a >> base);
        slice_b   = DIGIT'(op_b >> base);
        slice_sum = '0;
        chain     = '0;
        chain[0]  = carry;
        for (int i = 0; i < int'(DIGIT); i++) begin
            slice_sum[i] = slice_a[i] ^ slice_b[i] ^ chain[i];
            chain[i+1]   = (slice_a[i] & slice_b[i]) | (chain[i] & (slice_a[i] ^ slice_b[i]));
        end
        acc_nxt = (acc & ~(SLICE_MASK << base)) | (WIDTH'(slice_sum) << base);
    end

    // Operand latch, slice sequencing and completion capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_nxt == S_RUN);
            done_q <= (state == S_RUN) && last_c;
            if (accept_c) begin
                op_a  <= bus.a;
                op_b  <= bus.mode ? ~bus.b : bus.b;
                carry <= bus.mode ? ~bus.cin : bus.cin;
                cnt   <= '0;
            end else if (state == S_RUN) begin
                acc   <= acc_nxt;
                carry <= chain[DIGIT];
                cnt   <= cnt + CW'(1);
                if (last_c) begin
                    result_q <= acc_nxt;
                    cout_q   <= chain[DIGIT];
                    ovf_q    <= chain[DIGIT-1] ^ chain[DIGIT];
                    zero_q   <= (acc_nxt == '0);
                end
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_addsub_seq.sv
// Directed and swept checks of addsub_seq across four WIDTH/DIGIT configurations.
// Index 0 is 8/2 (directed tests); 1..3 are 8/1, 8/8 and 16/4 (random sweep).
module tb_addsub_seq;
    logic clk;
    logic rst_n;

    logic [3:0]       st;
    logic [3:0]       md;
    logic [3:0]       ci;
    logic [3:0][15:0] av;
    logic [3:0][15:0] bv;
    wire  [3:0]       bz;
    wire  [3:0]       dn;
    wire  [3:0]       cf;
    wire  [3:0]       of;
    wire  [3:0]       zf;
    wire  [3:0][15:0] rs;

    int errors = 0;
    int checks = 0;

    function automatic int unsigned w_of(input int g);
        return (g == 3) ? 16 : 8;
    endfunction

    function automatic int unsigned d_of(input int g);
        case (g)
            0:       return 2;
            1:       return 1;
            2:       return 8;
            default: return 4;
        endcase
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int unsigned W = w_of(g);
        localparam int unsigned D = d_of(g);
        addsub_seq_if #(.WIDTH(W)) bus ();
        addsub_seq #(.WIDTH(W), .DIGIT(D)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
        assign bus.start = st[g];
        assign bus.mode  = md[g];
        assign bus.cin   = ci[g];
        assign bus.a     = av[g][W-1:0];
        assign bus.b     = bv[g][W-1:0];
        assign bz[g]     = bus.busy;
        assign dn[g]     = bus.done;
        assign cf[g]     = bus.cout;
        assign of[g]     = bus.ovf;
        assign zf[g]     = bus.zero;
        assign rs[g]     = 16'(bus.result);
    end

    // Reference: {result, cout, ovf, zero} from integer arithmetic
    function automatic logic [18:0] model(input int w, input logic m, input logic [15:0] a,
                                          input logic [15:0] b, input logic c);
        int full, half, sa, sb, s;
        logic [15:0] r;
        logic co, ov;
        half = 1 << (w - 1);
        if (m) begin
            full = int'(a) - int'(b) - int'(c);
            co   = (full >= 0);
        end else begin
            full = int'(a) + int'(b) + int'(c);
            co   = (full >= (1 << w));
        end
        r  = 16'(full & ((1 << w) - 1));
        sa = (int'(a) >= half) ? int'(a) - 2 * half : int'(a);
        sb = (int'(b) >= half) ? int'(b) - 2 * half : int'(b);
        s  = m ? (sa - sb - int'(c)) : (sa + sb + int'(c));
        ov = (s >= half) || (s < -half);
        return {r, co, ov, (r == 16'h0)};
    endfunction

    // Called at a negedge; returns at the negedge after busy drops
    task automatic do_op(input int g, input logic m, input logic [15:0] a, input logic [15:0] b,
                         input logic c, output int ncyc);
        md[g] = m; av[g] = a; bv[g] = b; ci[g] = c; st[g] = 1'b1;
        @(negedge clk);
        st[g] = 1'b0;
        ncyc = 0;
        while (bz[g] === 1'b1 && ncyc < 64) begin
            ncyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bz[0], dn[0]} !== 2'b00) begin
            errors++;
            $display("FAIL reset busy/done: got %b expected 00", {bz[0], dn[0]});
        end
        checks++;
        if ({rs[0], cf[0], of[0], zf[0]} !== 19'h0) begin
            errors++;
            $display("FAIL reset result/flags: got %h expected 0", {rs[0], cf[0], of[0], zf[0]});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_ovf();
        int n;
        do_op(0, 1'b0, 16'h7F, 16'h01, 1'b0, n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL add_ovf busy cycles: got %0d expected 4", n); end
        checks++;
        if (dn[0] !== 1'b1) begin errors++; $display("FAIL add_ovf done: got %b expected 1", dn[0]); end
        checks++;
        if ({rs[0], cf[0], of[0], zf[0]} !== {16'h0080, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_ovf flags: got %h expected %h", {rs[0], cf[0], of[0], zf[0]},
                     {16'h0080, 1'b0, 1'b1, 1'b0});
        end
        @(negedge clk);
        checks++;
        if (dn[0] !== 1'b0) begin errors++; $display("FAIL add_ovf done pulse width: got %b expected 0", dn[0]); end
    endtask

    task automatic test_sub();
        int n;
        do_op(0, 1'b1, 16'h05, 16'h05, 1'b0, n);
        checks++;
        if ({rs[0], cf[0], of[0], zf[0]} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sub_zero flags: got %h expected %h", {rs[0], cf[0], of[0], zf[0]},
                     {16'h0000, 1'b1, 1'b0, 1'b1});
        end
        @(negedge clk);
        do_op(0, 1'b1, 16'h00, 16'h01, 1'b0, n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL sub_borrow busy cycles: got %0d expected 4", n); end
        checks++;
        if ({rs[0], cf[0], of[0], zf[0]} !== {16'h00FF, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow flags: got %h expected %h", {rs[0], cf[0], of[0], zf[0]},
                     {16'h00FF, 1'b0, 1'b0, 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int n;
        md[0] = 1'b0; av[0] = 16'hFF; bv[0] = 16'h01; ci[0] = 1'b1; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        n = 0;
        while (bz[0] === 1'b1 && n < 64) begin
            checks++;
            if ({dn[0], rs[0]} !== {1'b0, 16'h00FF}) begin
                errors++;
                $display("FAIL ignore_start hold: got %h expected %h", {dn[0], rs[0]}, {1'b0, 16'h00FF});
            end
            av[0] = 16'h12; bv[0] = 16'h34; md[0] = 1'b1; ci[0] = 1'b0; st[0] = ~st[0];
            n++;
            @(negedge clk);
        end
        st[0] = 1'b0;
        checks++;
        if (n !== 4) begin errors++; $display("FAIL ignore_start busy cycles: got %0d expected 4", n); end
        checks++;
        if ({dn[0], rs[0], cf[0], of[0], zf[0]} !== {1'b1, 16'h0001, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ignore_start flags: got %h expected %h", {dn[0], rs[0], cf[0], of[0], zf[0]},
                     {1'b1, 16'h0001, 1'b1, 1'b0, 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n;
        do_op(0, 1'b0, 16'h10, 16'h20, 1'b0, n);
        checks++;
        if ({dn[0], rs[0]} !== {1'b1, 16'h0030}) begin
            errors++;
            $display("FAIL b2b first: got %h expected %h", {dn[0], rs[0]}, {1'b1, 16'h0030});
        end
        md[0] = 1'b1; av[0] = 16'h80; bv[0] = 16'h01; ci[0] = 1'b0; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        checks++;
        if ({bz[0], dn[0]} !== 2'b10) begin
            errors++;
            $display("FAIL b2b busy after DONE-cycle start: got %b expected 10", {bz[0], dn[0]});
        end
        n = 0;
        while (bz[0] === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 4) begin errors++; $display("FAIL b2b second busy cycles: got %0d expected 4", n); end
        checks++;
        if ({dn[0], rs[0], cf[0], of[0], zf[0]} !== {1'b1, 16'h007F, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b second flags: got %h expected %h", {dn[0], rs[0], cf[0], of[0], zf[0]},
                     {1'b1, 16'h007F, 1'b1, 1'b1, 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int n;
        md[0] = 1'b0; av[0] = 16'h55; bv[0] = 16'hAA; ci[0] = 1'b0; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({bz[0], dn[0], rs[0], cf[0], of[0], zf[0]} !== 21'h0) begin
            errors++;
            $display("FAIL async_reset immediate: got %h expected 0", {bz[0], dn[0], rs[0], cf[0], of[0], zf[0]});
        end
        @(negedge clk);
        checks++;
        if ({bz[0], dn[0]} !== 2'b00) begin
            errors++;
            $display("FAIL async_reset held: got %b expected 00", {bz[0], dn[0]});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dn[0] !== 1'b0) begin errors++; $display("FAIL async_reset no done: got %b expected 0", dn[0]); end
        do_op(0, 1'b0, 16'h03, 16'h04, 1'b0, n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL post_reset busy cycles: got %0d expected 4", n); end
        checks++;
        if ({dn[0], rs[0], cf[0], of[0], zf[0]} !== {1'b1, 16'h0007, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL post_reset flags: got %h expected %h", {dn[0], rs[0], cf[0], of[0], zf[0]},
                     {1'b1, 16'h0007, 1'b0, 1'b0, 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic test_sweep();
        int n;
        int unsigned w, nexp;
        logic [15:0] msk, a, b;
        logic m, c;
        logic [18:0] exp_v;
        for (int g = 1; g < 4; g++) begin
            w    = w_of(g);
            nexp = w / d_of(g);
            msk  = 16'((32'd1 << w) - 32'd1);
            for (int i = 0; i < 1000; i++) begin
                a = 16'($urandom) & msk;
                b = 16'($urandom) & msk;
                m = 1'($urandom);
                c = 1'($urandom);
                exp_v = model(int'(w), m, a, b, c);
                do_op(g, m, a, b, c, n);
                checks++;
                if (n !== int'(nexp)) begin
                    errors++;
                    $display("FAIL sweep cfg%0d busy cycles: got %0d expected %0d", g, n, nexp);
                end
                checks++;
                if (dn[g] !== 1'b1) begin
                    errors++;
                    $display("FAIL sweep cfg%0d done: got %b expected 1", g, dn[g]);
                end
                checks++;
                if ({rs[g], cf[g], of[g], zf[g]} !== exp_v) begin
                    errors++;
                    $display("FAIL sweep cfg%0d m=%b a=%h b=%h c=%b: got %h expected %h",
                             g, m, a, b, c, {rs[g], cf[g], of[g], zf[g]}, exp_v);
                end
            end
        end
    endtask

    initial begin
        st = '0; md = '0; ci = '0; av = '0; bv = '0;
        rst_n = 1'b0;
        test_reset();
        test_add_ovf();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
